// File: rtl/sync_width_fifo.sv
// Single-clock FIFO with asymmetric write/read widths sharing unit-granular storage.
// Flags and water levels are decoded from the registered unit count.
module sync_width_fifo #(
  parameter int    WR_DATA_WIDTH  = 8,
  parameter int    RD_DATA_WIDTH  = 16,
  parameter int    DEPTH_WIDTH    = 10,
  parameter string LANE_ORDER     = "LSB_FIRST",
  localparam int   U              = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
  localparam int   WU             = WR_DATA_WIDTH / U,
  localparam int   RU             = RD_DATA_WIDTH / U,
  localparam int   WU_LOG         = $clog2(WU),
  localparam int   RU_LOG         = $clog2(RU),
  localparam int   WR_DEPTH_WIDTH = DEPTH_WIDTH - WU_LOG,
  localparam int   RD_DEPTH_WIDTH = DEPTH_WIDTH - RU_LOG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  output logic                      wr_full,
  output logic                      almost_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  input  logic [WR_DEPTH_WIDTH:0]   almost_full_num,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_empty,
  output logic                      almost_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  input  logic [RD_DEPTH_WIDTH:0]   almost_empty_num,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam bit MSB_FIRST = (LANE_ORDER == "MSB_FIRST");
  localparam logic [DEPTH_WIDTH:0]   WU_INC     = (DEPTH_WIDTH+1)'(WU);
  localparam logic [DEPTH_WIDTH:0]   RU_INC     = (DEPTH_WIDTH+1)'(RU);
  localparam logic [DEPTH_WIDTH:0]   FULL_LIMIT = (DEPTH_WIDTH+1)'(DEPTH - WU);
  localparam logic [DEPTH_WIDTH-1:0] WU_PTR     = DEPTH_WIDTH'(WU);
  localparam logic [DEPTH_WIDTH-1:0] RU_PTR     = DEPTH_WIDTH'(RU);

  logic [U-1:0]             mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]     cnt_q, cnt_d;
  logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     wr_accept, rd_accept;
  logic [U-1:0]             wr_unit [WU];
  logic [RD_DATA_WIDTH-1:0] rd_word;

  // Lane k of the wide word holds the k-th oldest unit, mirrored for MSB_FIRST.
  for (genvar k = 0; k < WU; k++) begin : g_wr_lane
    localparam int LANE = MSB_FIRST ? (WU - 1 - k) : k;
    assign wr_unit[k] = wr_data[LANE*U +: U];
  end

  for (genvar k = 0; k < RU; k++) begin : g_rd_lane
    localparam int LANE = MSB_FIRST ? (RU - 1 - k) : k;
    assign rd_word[LANE*U +: U] = mem_q[rd_ptr_q + DEPTH_WIDTH'(k)];
  end

  assign wr_full        = cnt_q > FULL_LIMIT;
  assign rd_empty       = cnt_q < RU_INC;
  assign wr_water_level = cnt_q[DEPTH_WIDTH:WU_LOG];
  assign rd_water_level = cnt_q[DEPTH_WIDTH:RU_LOG];
  assign almost_full    = wr_water_level >= almost_full_num;
  assign almost_empty   = rd_water_level <= almost_empty_num;
  assign rd_data        = rd_data_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  assign wr_accept = wr_en & ~wr_full & ~flush;
  assign rd_accept = rd_en & ~rd_empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      rd_data_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + WU_PTR;
      if (rd_accept) begin
        rd_ptr_d  = rd_ptr_q + RU_PTR;
        rd_data_d = rd_word;
      end
      cnt_d = cnt_q + (wr_accept ? WU_INC : '0) - (rd_accept ? RU_INC : '0);
      if (wr_en && wr_full)  overflow_d  = 1'b1;
      if (rd_en && rd_empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: cnt and the pointers define which units are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int k = 0; k < WU; k++) begin
        mem_q[wr_ptr_q + DEPTH_WIDTH'(k)] <= wr_unit[k];
      end
    end
  end

endmodule

// File: tb/tb_sync_width_fifo.sv
// Directed bench: 8->16 LSB_FIRST (depth 1024 units) and 32->8 MSB_FIRST (depth 16 units).
module tb_sync_width_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_wr_en, a_rd_en;
  logic [7:0]  a_wr_data;
  logic        a_wr_full, a_af, a_rd_empty, a_ae, a_of, a_uf;
  logic [10:0] a_wl, a_af_num;
  logic [15:0] a_rd_data;
  logic [9:0]  a_rl, a_ae_num;

  logic        b_flush, b_wr_en, b_rd_en;
  logic [31:0] b_wr_data;
  logic        b_wr_full, b_af, b_rd_empty, b_ae, b_of, b_uf;
  logic [2:0]  b_wl, b_af_num;
  logic [7:0]  b_rd_data;
  logic [4:0]  b_rl, b_ae_num;

  sync_width_fifo #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(10), .LANE_ORDER("LSB_FIRST")) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_full(a_wr_full), .almost_full(a_af),
    .wr_water_level(a_wl), .almost_full_num(a_af_num),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_empty(a_rd_empty), .almost_empty(a_ae),
    .rd_water_level(a_rl), .almost_empty_num(a_ae_num),
    .overflow(a_of), .underflow(a_uf));

  sync_width_fifo #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(4), .LANE_ORDER("MSB_FIRST")) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_full(b_wr_full), .almost_full(b_af),
    .wr_water_level(b_wl), .almost_full_num(b_af_num),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_empty(b_rd_empty), .almost_empty(b_ae),
    .rd_water_level(b_rl), .almost_empty_num(b_ae_num),
    .overflow(b_of), .underflow(b_uf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bval(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic logic [31:0] bword(input int j);
    return {8'(4 * j), 8'(4 * j + 1), 8'(4 * j + 2), 8'(4 * j + 3)};
  endfunction

  typedef struct {
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic        flush;
    logic [15:0] rd_data;
    logic        rd_empty;
    logic        wr_full;
    logic [10:0] wl;
    logic [9:0]  rl;
    logic        af;
    logic        ae;
    logic        of;
    logic        uf;
  } vec_t;

  vec_t vt [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  exp_b [4];
    logic [7:0]  q [$];
    logic [7:0]  eb;
    logic [31:0] w;
    logic [15:0] last;
    int          n;
    int          j;

    // wr rd data  rd fl | rd_data empty full wl rl af ae of uf   (almost_full_num=2, almost_empty_num=0)
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 11'd1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 11'd2, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h2211, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h2211, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 16'h2211, 1'b1, 1'b0, 11'd1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 8'h44, 1'b1, 1'b0, 16'h2211, 1'b0, 1'b0, 11'd2, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 8'h55, 1'b1, 1'b0, 16'h4433, 1'b1, 1'b0, 11'd1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 8'h66, 1'b0, 1'b0, 16'h4433, 1'b0, 1'b0, 11'd2, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 8'h99, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 8'h77, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 11'd1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'h88, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 11'd2, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h8877, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
    a_af_num = '0; a_ae_num = '0;
    b_flush = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
    b_af_num = '0; b_ae_num = '0;
    repeat (2) tick();

    chk("rst_rd_data", a_rd_data, 16'h0);
    chk("rst_rd_empty", a_rd_empty, 1'b1);
    chk("rst_wr_full", a_wr_full, 1'b0);
    chk("rst_wl", a_wl, 11'd0);
    chk("rst_rl", a_rl, 10'd0);
    chk("rst_ae", a_ae, 1'b1);
    chk("rst_af_num0", a_af, 1'b1);
    chk("rst_of", a_of, 1'b0);
    chk("rst_uf", a_uf, 1'b0);
    chk("rst_b_empty", b_rd_empty, 1'b1);

    rst = 1'b0;
    a_af_num = 11'd2;
    tick();

    for (int i = 0; i < 13; i++) begin
      a_wr_en = vt[i].wr_en; a_wr_data = vt[i].wr_data;
      a_rd_en = vt[i].rd_en; a_flush = vt[i].flush;
      tick();
      chk($sformatf("vec%0d_rd_data", i), a_rd_data, vt[i].rd_data);
      chk($sformatf("vec%0d_empty", i), a_rd_empty, vt[i].rd_empty);
      chk($sformatf("vec%0d_full", i), a_wr_full, vt[i].wr_full);
      chk($sformatf("vec%0d_wl", i), a_wl, vt[i].wl);
      chk($sformatf("vec%0d_rl", i), a_rl, vt[i].rl);
      chk($sformatf("vec%0d_af", i), a_af, vt[i].af);
      chk($sformatf("vec%0d_ae", i), a_ae, vt[i].ae);
      chk($sformatf("vec%0d_of", i), a_of, vt[i].of);
      chk($sformatf("vec%0d_uf", i), a_uf, vt[i].uf);
    end
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_flush = 1'b0;

    // Fill to full while watching the thresholds.
    a_af_num = 11'd252;
    a_ae_num = 10'd4;
    for (int i = 0; i < 1024; i++) begin
      a_wr_en = 1'b1; a_wr_data = bval(i);
      tick();
      n = i + 1;
      if (n == 9)   chk("ae_at_rl4", a_ae, 1'b1);
      if (n == 10) begin
        chk("ae_at_rl5", a_ae, 1'b0);
        chk("rl_at_10", a_rl, 10'd5);
      end
      if (n == 251) chk("af_at_251", a_af, 1'b0);
      if (n == 252) chk("af_at_252", a_af, 1'b1);
      if (n == 260) begin
        a_af_num = 11'd300;
        #1;
        chk("af_thresh_raise", a_af, 1'b0);
      end
      if (n == 300) chk("af_at_300", a_af, 1'b1);
      if (n == 1023) chk("full_at_1023", a_wr_full, 1'b0);
    end
    a_wr_en = 1'b0;
    chk("fill_full", a_wr_full, 1'b1);
    chk("fill_wl", a_wl, 11'd1024);
    chk("fill_rl", a_rl, 10'd512);
    chk("fill_of", a_of, 1'b0);

    a_wr_en = 1'b1; a_wr_data = 8'hFF;
    tick();
    a_wr_en = 1'b0;
    chk("ovf_flag", a_of, 1'b1);
    chk("ovf_wl", a_wl, 11'd1024);
    chk("ovf_full", a_wr_full, 1'b1);

    for (int k = 0; k < 512; k++) begin
      a_rd_en = 1'b1;
      tick();
      chk("drain_data", a_rd_data, {bval(2 * k + 1), bval(2 * k)});
      if (k == 0) chk("drain_unfull", a_wr_full, 1'b0);
    end
    a_rd_en = 1'b0;
    last = {bval(1023), bval(1022)};
    chk("drain_empty", a_rd_empty, 1'b1);
    chk("drain_rl", a_rl, 10'd0);
    chk("drain_uf_pre", a_uf, 1'b0);

    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    chk("udf_flag", a_uf, 1'b1);
    chk("udf_hold", a_rd_data, last);

    // Flush with cnt = 10 and both requests active.
    for (int i = 0; i < 10; i++) begin
      a_wr_en = 1'b1; a_wr_data = 8'(i);
      tick();
    end
    a_wr_en = 1'b0;
    chk("pre_flush_wl", a_wl, 11'd10);
    chk("pre_flush_rl", a_rl, 10'd5);
    chk("pre_flush_of", a_of, 1'b1);
    a_flush = 1'b1; a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'hEE;
    tick();
    a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    chk("flush_wl", a_wl, 11'd0);
    chk("flush_empty", a_rd_empty, 1'b1);
    chk("flush_of", a_of, 1'b0);
    chk("flush_uf", a_uf, 1'b0);
    chk("flush_rd_data", a_rd_data, 16'h0);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1'b1; a_wr_data = 8'(8'hA0 + i);
      tick();
    end
    a_wr_en = 1'b0; a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    chk("mid_rd_data", a_rd_data, 16'hA1A0);
    a_rd_en = 1'b1; a_wr_en = 1'b1; a_wr_data = 8'hB0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rd_data", a_rd_data, 16'h0);
    chk("arst_empty", a_rd_empty, 1'b1);
    chk("arst_full", a_wr_full, 1'b0);
    chk("arst_wl", a_wl, 11'd0);
    chk("arst_rl", a_rl, 10'd0);
    chk("arst_ae", a_ae, 1'b1);
    chk("arst_af", a_af, 1'b0);
    chk("arst_of", a_of, 1'b0);
    chk("arst_uf", a_uf, 1'b0);
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Downsize 32->8, MSB_FIRST.
    b_wr_en = 1'b1; b_wr_data = 32'hA1B2C3D4;
    tick();
    b_wr_en = 1'b0;
    chk("b_rl_after_wr", b_rl, 5'd4);
    chk("b_wl_after_wr", b_wl, 3'd1);
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    for (int k = 0; k < 4; k++) begin
      b_rd_en = 1'b1;
      tick();
      chk($sformatf("b_byte%0d", k), b_rd_data, exp_b[k]);
    end
    b_rd_en = 1'b0;
    chk("b_empty", b_rd_empty, 1'b1);

    // Continuous simultaneous traffic across several pointer wraps.
    j = 0;
    for (int p = 0; p < 2; p++) begin
      w = bword(j); j++;
      b_wr_en = 1'b1; b_wr_data = w;
      q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
      tick();
    end
    b_wr_en = 1'b0;
    for (int c = 0; c < 64; c++) begin
      b_rd_en = 1'b1;
      eb = q.pop_front();
      b_wr_en = (c % 4 == 0);
      if (b_wr_en) begin
        w = bword(j); j++;
        b_wr_data = w;
        q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
      end
      tick();
      chk("b_stream_data", b_rd_data, eb);
      chk("b_stream_rl", b_rl, 5'(q.size()));
    end
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    chk("b_stable", b_rl, 5'd8);

    b_wr_en = 1'b1; b_wr_data = bword(j);
    tick();
    chk("b_at_12_full", b_wr_full, 1'b0);
    b_wr_data = bword(j + 1);
    tick();
    b_wr_en = 1'b0;
    chk("b_at_16_full", b_wr_full, 1'b1);
    chk("b_at_16_wl", b_wl, 3'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_width_fifo.md
# sync_width_fifo

Single-clock FIFO with parametrised asymmetric data width (upsize or downsize by 1, 2, 4 or 8), selectable lane order, run-time programmable almost-full/almost-empty thresholds, per-side water levels, synchronous flush and sticky overflow/underflow flags. It sits between same-clock stages of the audio/UDP datapath, for example packing 8-bit UDP payload bytes into 16-bit samples or unpacking 32-bit FFT words into bytes. It replaces fixed-configuration generated FIFOs wherever no clock crossing is needed.

## Interface
- WR_DATA_WIDTH, 8, write word width.
- RD_DATA_WIDTH, 16, read word width. The larger of the two widths must be 1, 2, 4 or 8 times the smaller.
- DEPTH_WIDTH, 10, log2 of storage depth in units. Unit width U = min(WR_DATA_WIDTH, RD_DATA_WIDTH).
- LANE_ORDER, "LSB_FIRST", either "LSB_FIRST" or "MSB_FIRST". Selects which lane of the wide word is the oldest unit.
- Derived values: WU = WR_DATA_WIDTH/U and RU = RD_DATA_WIDTH/U.
- Derived values: WR_DEPTH_WIDTH = DEPTH_WIDTH − log2(WU) and RD_DEPTH_WIDTH = DEPTH_WIDTH − log2(RU).
- clk, input, 1: the single clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous clear.
- wr_en, input, 1: write request.
- wr_data, input, WR_DATA_WIDTH: write data.
- wr_full, output, 1: a further write cannot be accepted.
- almost_full, output, 1: wr_water_level ≥ almost_full_num.
- wr_water_level, output, WR_DEPTH_WIDTH+1: stored data expressed in write words.
- almost_full_num, input, WR_DEPTH_WIDTH+1: threshold for almost_full.
- rd_en, input, 1: read request.
- rd_data, output, RD_DATA_WIDTH: read data.
- rd_empty, output, 1: a full read word is not available.
- almost_empty, output, 1: rd_water_level ≤ almost_empty_num.
- rd_water_level, output, RD_DEPTH_WIDTH+1: stored data expressed in read words.
- almost_empty_num, input, RD_DEPTH_WIDTH+1: threshold for almost_empty.
- overflow, output, 1: sticky; set when a write was attempted while full.
- underflow, output, 1: sticky; set when a read was attempted while empty.

## Operation
- **Storage:** circular buffer of 2^DEPTH_WIDTH units.
  - Registered unit count cnt ranges over 0..2^DEPTH_WIDTH, which needs DEPTH_WIDTH+1 bits.
  - Write pointer and read pointer are unit addresses that wrap modulo 2^DEPTH_WIDTH.
- **Write acceptance:** a write is accepted when wr_en=1 and wr_full=0.
  - It stores WU units at the write pointer. The write pointer advances by WU.
  - With LSB_FIRST, wr_data[U−1:0] is the oldest unit. With MSB_FIRST, the top lane is the oldest unit.
- **Read acceptance:** a read is accepted when rd_en=1 and rd_empty=0.
  - It fetches RU units from the read pointer. The read pointer advances by RU.
  - The oldest unit lands in rd_data[U−1:0] for LSB_FIRST, or in the top lane for MSB_FIRST.
- **Alignment:** pointers only ever move in multiples of WU or RU, and all of these are powers of two dividing the depth, so accesses never straddle the wrap point.
- **Count update:** cnt_next = cnt + (write accepted ? WU : 0) − (read accepted ? RU : 0).
- **Flags, all decoded from the registered cnt:**
  - wr_full = (2^DEPTH_WIDTH − cnt) < WU.
  - rd_empty = cnt < RU.
  - wr_water_level = cnt >> log2(WU).
  - rd_water_level = cnt >> log2(RU).
- **Simultaneous read and write:** both are judged on the flags before the edge, and both may be accepted in the same cycle. A read accepted while the FIFO is full frees space only from the next cycle.
- **Rejected requests:**
  - wr_en while full is dropped and sets overflow.
  - rd_en while empty is dropped, sets underflow and leaves rd_data unchanged.
- **Flush:** clears both pointers, cnt, overflow, underflow and rd_data. Any wr_en or rd_en in the same cycle is ignored and sets neither sticky flag.
- **Thresholds:** almost_full_num and almost_empty_num are sampled combinationally every cycle and may change at any time.
- **Reset:** behaves like flush, but is asynchronous and overrides everything, including in the middle of an operation.

## Timing
- Reset values of all outputs:
  - rd_data = 0.
  - rd_empty = 1 and wr_full = 0.
  - wr_water_level = 0 and rd_water_level = 0.
  - almost_empty = 1, because 0 ≤ any threshold.
  - almost_full = (almost_full_num == 0).
  - overflow = 0 and underflow = 0.
- Read latency is 1 cycle: rd_data is registered on the accepting edge, is valid from the next cycle, and holds until the next accepted read.
- Write-to-read latency is 1 cycle: data written on edge N can be read from edge N+1, provided cnt ≥ RU after edge N.
- Flags and water levels are registered-state decodes and update on the edge after the accepted operation. There is no lookahead.

## Test plan
- **Upsize, default 8→16, LSB_FIRST:** write 0x11 then 0x22, read once → rd_data = 0x2211 one cycle after rd_en. A single written byte leaves rd_empty = 1 and rd_water_level = 0.
- **Fill to full:** write 1024 bytes → wr_full = 1, wr_water_level = 1024, rd_water_level = 512. A 1025th write sets overflow = 1 and cnt is unchanged. Drain 512 reads → data matches in order, then rd_empty = 1. A 513th read sets underflow and rd_data holds its last value.
- **Thresholds:** set almost_full_num = 252 and almost_empty_num = 4.
  - almost_full asserts on the edge after byte 252 is written.
  - almost_empty deasserts when rd_water_level reaches 5.
  - Changing almost_full_num to 300 mid-fill clears almost_full combinationally.
- **Downsize, 32→8, MSB_FIRST, DEPTH_WIDTH 4:** write 0xA1B2C3D4 → reads return A1, B2, C3, D4. Run continuous simultaneous write and read across several pointer wraps → no data loss and cnt stays stable.
- **Flush and reset:** with cnt = 10, assert flush together with wr_en and rd_en → cnt = 0, rd_empty = 1 and sticky flags cleared. Assert rst asynchronously mid-stream → all outputs take their reset values before the next clock edge.
